// File: rtl/gpu_pkg.sv
// Shared GPU definitions: frame geometry defaults, pixel queue entry, address helper.
package gpu_pkg;

  localparam int unsigned GPU_FB_W      = 256;
  localparam int unsigned GPU_FB_H      = 192;
  localparam int unsigned GPU_BASE_ADDR = 49152;
  localparam int unsigned PIX_ADDR_W    = 32;
  localparam int unsigned PIX_COLOR_W   = 8;

  // One queued pixel write: VRAM byte address plus colour.
  typedef struct packed {
    logic [PIX_ADDR_W-1:0]  addr;
    logic [PIX_COLOR_W-1:0] color;
  } pix_entry_t;

  // Byte address of (x, y) in the back frame; side=1 means frame 1 is shown, so draw at offset 0.
  function automatic logic [PIX_ADDR_W-1:0] pix_lin_addr(
    input logic        side,
    input logic [9:0]  x,
    input logic [9:0]  y,
    input int unsigned fb_w,
    input int unsigned base
  );
    logic [PIX_ADDR_W-1:0] frame_base;
    frame_base   = side ? PIX_ADDR_W'(0) : PIX_ADDR_W'(base);
    pix_lin_addr = frame_base + PIX_ADDR_W'(y) * PIX_ADDR_W'(fb_w) + PIX_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_writer_fifo.sv
// pixel_fifo: small FIFO of pix_entry_t with registered full/empty flags.
// full_o reads high while in reset so no entry can be accepted until the first edge after release.
module pixel_fifo
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  pix_entry_t push_data_i,
  input  logic       pop_i,
  output pix_entry_t pop_data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  pix_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push    = push_i & ~full_q;
  assign do_pop     = pop_i & ~empty_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards everything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == CNT_W'(0));
    end
  end

  // Entry storage, written on accepted push only.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pixel_writer.sv
// pixel_writer: queues rasterizer pixels and merges them with cmd_clear writes onto VRAM port B.
// Clear writes always win; pixels drain one per cycle otherwise.
// Build option PIXEL_WRITER_CLIP_EN: drop off-frame pixels and count them in clip_count.
module pixel_writer
  import gpu_pkg::*;
#(
  parameter int unsigned FB_W       = GPU_FB_W,
  parameter int unsigned FB_H       = GPU_FB_H,
  parameter int unsigned BASE_ADDR  = GPU_BASE_ADDR,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              side,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic [7:0]        pix_color,
  input  logic              clear_we,
  input  logic [ADDR_W-1:0] clear_addr,
  input  logic [7:0]        clear_data,
  output logic              vram_we_b,
  output logic [ADDR_W-1:0] vram_addr_b,
  output logic [7:0]        vram_data_b,
  output logic              busy,
  output logic [15:0]       clip_count
);

  logic              fifo_full, fifo_empty;
  logic              accept, in_frame, push, pop;
  pix_entry_t        push_entry, head_entry;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              unused_addr_hi;

  assign pix_ready      = ~fifo_full;
  assign busy           = ~fifo_empty;
  assign accept         = pix_valid & pix_ready;
  assign in_frame       = (32'(pix_x) < FB_W) && (32'(pix_y) < FB_H);
  assign pop            = ~clear_we & ~fifo_empty;
  assign unused_addr_hi = ^head_entry.addr[PIX_ADDR_W-1:ADDR_W];

  // Address is fixed at accept time so later side swaps do not move queued pixels.
  always_comb begin
    push_entry       = '0;
    push_entry.addr  = pix_lin_addr(side, pix_x, pix_y, FB_W, BASE_ADDR);
    push_entry.color = pix_color;
  end

`ifdef PIXEL_WRITER_CLIP_EN
  logic [15:0] clip_q, clip_d;

  assign push       = accept & in_frame;
  assign clip_count = clip_q;

  // Saturating count of accepted-but-dropped off-frame pixels.
  always_comb begin
    clip_d = clip_q;
    if (accept && !in_frame && (clip_q != 16'hFFFF)) clip_d = clip_q + 16'd1;
  end

  // Clip counter register.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) clip_q <= '0;
    else      clip_q <= clip_d;
  end
`else
  logic unused_in_frame;

  assign unused_in_frame = in_frame;
  assign push            = accept;
  assign clip_count      = 16'h0;
`endif

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Port-B mux: clear first, then queued pixel; idle cycles keep addr/data.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (clear_we) begin
      we_d   = 1'b1;
      addr_d = clear_addr;
      data_d = clear_data;
    end else if (pop) begin
      we_d   = 1'b1;
      addr_d = ADDR_W'(head_entry.addr);
      data_d = head_entry.color;
    end
  end

  // Registered VRAM port-B outputs.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign vram_we_b   = we_q;
  assign vram_addr_b = addr_q;
  assign vram_data_b = data_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer (default parameters, FB 256x192, frame base 49152).
// Expected port-B writes are queued when stimulus is driven (clear and pixel streams
// kept separately) and popped when the DUT writes. Honours PIXEL_WRITER_CLIP_EN.
module tb_pixel_writer;

  typedef struct packed {
    logic [17:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        CLK = 1'b0;
  logic        rst;
  logic        side;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x, pix_y;
  logic [7:0]  pix_color;
  logic        clear_we;
  logic [17:0] clear_addr;
  logic [7:0]  clear_data;
  logic        vram_we_b;
  logic [17:0] vram_addr_b;
  logic [7:0]  vram_data_b;
  logic        busy;
  logic [15:0] clip_count;

  int          errors = 0;
  int          checks = 0;
  int          wr_cnt = 0;
  logic [15:0] exp_clip = 16'h0;
  wr_t         exp_clr[$];
  wr_t         exp_pix[$];

  pixel_writer dut (
    .CLK         (CLK),
    .rst         (rst),
    .side        (side),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .clear_we    (clear_we),
    .clear_addr  (clear_addr),
    .clear_data  (clear_data),
    .vram_we_b   (vram_we_b),
    .vram_addr_b (vram_addr_b),
    .vram_data_b (vram_data_b),
    .busy        (busy),
    .clip_count  (clip_count)
  );

  initial forever #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model_addr(input logic s, input int x, input int y);
    int base;
    base = s ? 0 : 49152;
    return 18'(base + y * 256 + x);
  endfunction

  // One clock: log what the next edge will do, then check the write it produces.
  task automatic step(output bit acc);
    bit  clr;
    wr_t e;
    clr = (clear_we === 1'b1);
    acc = (pix_valid === 1'b1) && (pix_ready === 1'b1);
    if (clr) exp_clr.push_back({clear_addr, clear_data});
    if (acc) begin
`ifdef PIXEL_WRITER_CLIP_EN
      if (pix_x >= 10'd256 || pix_y >= 10'd192) begin
        if (exp_clip != 16'hFFFF) exp_clip = exp_clip + 16'd1;
      end else
        exp_pix.push_back({model_addr(side, int'(pix_x), int'(pix_y)), pix_color});
`else
      exp_pix.push_back({model_addr(side, int'(pix_x), int'(pix_y)), pix_color});
`endif
    end
    @(negedge CLK);
    if (clr) begin
      wr_cnt++;
      check("clr_we", 32'(vram_we_b), 32'd1);
      e = exp_clr.pop_front();
      check("clr_addr", 32'(vram_addr_b), 32'(e.a));
      check("clr_data", 32'(vram_data_b), 32'(e.d));
    end else if (vram_we_b === 1'b1) begin
      wr_cnt++;
      if (exp_pix.size() == 0) begin
        check("unexpected_wr", 32'(vram_we_b), 32'd0);
      end else begin
        e = exp_pix.pop_front();
        check("pix_addr", 32'(vram_addr_b), 32'(e.a));
        check("pix_data", 32'(vram_data_b), 32'(e.d));
      end
    end
  endtask

  task automatic tick();
    bit a;
    step(a);
  endtask

  // Idle until every expected pixel has been written, bounded.
  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && (exp_pix.size() != 0 || busy === 1'b1); i++) tick();
    check("drain_empty", 32'(exp_pix.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic set_pix(input int x, input int y, input logic [7:0] c);
    pix_valid = 1'b1;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_color = c;
  endtask

  initial begin
    bit acc;
    int idx;
    int w0;

    rst = 1'b1; side = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
    clear_we = 1'b0; clear_addr = '0; clear_data = '0;
    #1 rst = 1'b0;
    #2;
    check("rst_we", 32'(vram_we_b), 32'd0);
    check("rst_addr", 32'(vram_addr_b), 32'd0);
    check("rst_data", 32'(vram_data_b), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clip", 32'(clip_count), 32'd0);
    @(negedge CLK);
    rst = 1'b1;
    #1 check("ready_before_edge", 32'(pix_ready), 32'd0);
    tick();
    check("ready_after_release", 32'(pix_ready), 32'd1);

    // Single pixel, side=1: written two edges after accept at 515.
    side = 1'b1;
    set_pix(3, 2, 8'h1F);
    tick();
    pix_valid = 1'b0;
    check("lat_n1_we", 32'(vram_we_b), 32'd0);
    tick();
    check("s1_we", 32'(vram_we_b), 32'd1);
    check("s1_addr", 32'(vram_addr_b), 32'd515);
    check("s1_data", 32'(vram_data_b), 32'h1F);
    tick();
    check("idle_we", 32'(vram_we_b), 32'd0);
    check("idle_hold_addr", 32'(vram_addr_b), 32'd515);

    // Same pixel, side=0: frame base 49152.
    side = 1'b0;
    set_pix(3, 2, 8'h1F);
    tick();
    pix_valid = 1'b0;
    tick();
    check("s0_addr", 32'(vram_addr_b), 32'd49667);

    // Clear held 3 cycles while 2 pixels queue; clears go out first.
    side = 1'b1;
    clear_we = 1'b1; clear_addr = 18'd100; clear_data = 8'hA0;
    set_pix(10, 5, 8'h55);
    tick();
    clear_addr = 18'd101; clear_data = 8'hA1;
    set_pix(11, 5, 8'h56);
    tick();
    pix_valid = 1'b0;
    side = 1'b0;
    clear_addr = 18'd102; clear_data = 8'hA2;
    tick();
    check("clr_busy", 32'(busy), 32'd1);
    clear_we = 1'b0;
    tick();
    check("after_clr_p1", 32'(vram_addr_b), 32'd1290);
    tick();
    check("after_clr_p2", 32'(vram_addr_b), 32'd1291);
    drain(10);

    // Six back-to-back pixels against a continuous clear: queue fills at 4.
    side = 1'b1;
    clear_we = 1'b1;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      clear_addr = 18'(300 + c);
      clear_data = 8'(c);
      set_pix(idx, 7, 8'(8'h80 + idx));
      step(acc);
      if (acc) begin
        idx++;
        if (idx == 4) check("ready_low_at_full", 32'(pix_ready), 32'd0);
      end
    end
    check("accepted_in_clear", 32'(idx), 32'd4);
    check("ready_still_low", 32'(pix_ready), 32'd0);
    clear_we = 1'b0;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      set_pix(idx, 7, 8'(8'h80 + idx));
      step(acc);
      if (acc) idx++;
    end
    pix_valid = 1'b0;
    check("all_accepted", 32'(idx), 32'd6);
    drain(20);

    // Off-frame pixels.
    w0 = wr_cnt;
    set_pix(256, 0, 8'h11);
    tick();
    set_pix(0, 192, 8'h22);
    tick();
    pix_valid = 1'b0;
    repeat (4) tick();
`ifdef PIXEL_WRITER_CLIP_EN
    check("clip_writes", 32'(wr_cnt - w0), 32'd0);
    check("clip_count", 32'(clip_count), 32'd2);
`else
    check("noclip_writes", 32'(wr_cnt - w0), 32'd2);
    check("noclip_count", 32'(clip_count), 32'd0);
`endif
    check("clip_model", 32'(clip_count), 32'(exp_clip));

    // Reset with three pixels held in the queue behind a clear.
    clear_we = 1'b1;
    for (int c = 0; c < 3; c++) begin
      clear_addr = 18'(500 + c);
      clear_data = 8'(8'hC0 + c);
      set_pix(20 + c, 9, 8'(8'h40 + c));
      tick();
    end
    pix_valid = 1'b0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    clear_we = 1'b0;
    #1;
    check("arst_we", 32'(vram_we_b), 32'd0);
    check("arst_addr", 32'(vram_addr_b), 32'd0);
    check("arst_data", 32'(vram_data_b), 32'd0);
    check("arst_ready", 32'(pix_ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_clip", 32'(clip_count), 32'd0);
    exp_pix.delete();
    exp_clip = 16'h0;
    @(negedge CLK);
    #3 rst = 1'b1;
    #1 check("rel_ready_pre_edge", 32'(pix_ready), 32'd0);
    tick();
    check("rel_ready_edge1", 32'(pix_ready), 32'd1);
    w0 = wr_cnt;
    repeat (6) tick();
    check("no_stale_writes", 32'(wr_cnt - w0), 32'd0);
    check("clr_queue_empty", 32'(exp_clr.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
